// File: rtl/calc_core_param_if.sv
// Bus between the calculator core and the keypad/display layer.
// Inputs to the core : key (one-hot digit), append, set (level buttons), op (one-hot operator).
// Outputs of the core: state, digit_cnt, entry_value, result, result_neg, div_zero, busy, done.
// master modport drives the buttons and watches status; slave modport is the core.
interface calc_core_param_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WIDTH  = 32
);
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  logic [9:0]       key;
  logic             append;
  logic             set;
  logic [3:0]       op;
  logic [2:0]       state;
  logic [CNT_W-1:0] digit_cnt;
  logic [WIDTH-1:0] entry_value;
  logic [WIDTH-1:0] result;
  logic             result_neg;
  logic             div_zero;
  logic             busy;
  logic             done;

  modport master (
    output key, append, set, op,
    input  state, digit_cnt, entry_value, result, result_neg, div_zero, busy, done
  );

  modport slave (
    input  key, append, set, op,
    output state, digit_cnt, entry_value, result, result_neg, div_zero, busy, done
  );
endinterface

// File: rtl/calc_core_param.sv
// Arithmetic core of the push-button calculator.
// Assembles two decimal operands from one-hot digit keys, takes a one-hot
// operator and computes add/sub (1 cycle) or mul/div (WIDTH-cycle shift-add /
// restoring division). Results and status are registered.
// Ports: clk, rst (synchronous, active-high), bus (calc_core_param_if.slave).
// Optional build macro CALC_CHAIN_EN: from RESULT, set with a valid operator
// reuses the result as operand A and jumps straight to operand B entry.
module calc_core_param #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WIDTH  = 32
) (
  input  logic clk,
  input  logic rst,
  calc_core_param_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
  localparam int unsigned STEP_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPA    = 3'd1,
    S_OPSEL  = 3'd2,
    S_OPB    = 3'd3,
    S_CALC   = 3'd4,
    S_RESULT = 3'd5
  } state_e;

  state_e             state_q;
  logic               app_prev_q, set_prev_q;
  logic [WIDTH-1:0]   entry_q, a_q, b_q, result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         op_q;
  logic               neg_q, dz_q, busy_q, done_q;
  logic [STEP_W-1:0]  step_q;
  // Shared mul/div datapath: wa = multiplicand / quotient, wb = multiplier,
  // acc = product accumulator / partial remainder.
  logic [WIDTH-1:0]   wa_q, wb_q, acc_q;

  logic               app_e, set_e, key_onehot, op_onehot, app_ok, last_step, div_ge;
  logic [3:0]         key_idx;
  logic [WIDTH-1:0]   entry_d, mul_acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [WIDTH:0]     rem_sh, rem_sub;

  // Button edge detect and operand append datapath.
  always_comb begin
    app_e      = bus.append & ~app_prev_q;
    set_e      = bus.set & ~set_prev_q;
    key_onehot = (bus.key != 10'd0) && ((bus.key & (bus.key - 10'd1)) == 10'd0);
    op_onehot  = (bus.op != 4'd0) && ((bus.op & (bus.op - 4'd1)) == 4'd0);
    key_idx    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.key[i]) key_idx = 4'(i);
    end
    app_ok  = app_e && key_onehot && (cnt_q < CNT_W'(DIGITS));
    entry_d = app_ok ? (entry_q * WIDTH'(10)) + WIDTH'(key_idx) : entry_q;
    cnt_d   = app_ok ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // One step of shift-add multiply and restoring divide.
  always_comb begin
    mul_acc_d = wb_q[0] ? acc_q + wa_q : acc_q;
    rem_sh    = {acc_q, wa_q[WIDTH-1]};
    rem_sub   = rem_sh - {1'b0, b_q};
    div_ge    = rem_sh >= {1'b0, b_q};
    last_step = (step_q == STEP_W'(WIDTH - 1));
  end

  // Calculator FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      app_prev_q <= 1'b0;
      set_prev_q <= 1'b0;
      entry_q    <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= '0;
      wa_q       <= '0;
      wb_q       <= '0;
      acc_q      <= '0;
    end else begin
      app_prev_q <= bus.append;
      set_prev_q <= bus.set;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          entry_q  <= '0;
          cnt_q    <= '0;
          result_q <= '0;
          neg_q    <= 1'b0;
          dz_q     <= 1'b0;
          if (set_e) state_q <= S_OPA;
        end
        S_OPA: begin
          // Append first so a simultaneous set latches the updated entry.
          entry_q <= entry_d;
          cnt_q   <= cnt_d;
          if (set_e) begin
            a_q     <= entry_d;
            state_q <= S_OPSEL;
          end
        end
        S_OPSEL: begin
          if (set_e && op_onehot) begin
            op_q    <= bus.op;
            entry_q <= '0;
            cnt_q   <= '0;
            state_q <= S_OPB;
          end
        end
        S_OPB: begin
          entry_q <= entry_d;
          cnt_q   <= cnt_d;
          if (set_e) begin
            b_q     <= entry_d;
            entry_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            step_q  <= '0;
            wa_q    <= a_q;
            wb_q    <= entry_d;
            acc_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          neg_q <= 1'b0;
          dz_q  <= 1'b0;
          if (op_q[0]) begin
            result_q <= a_q + b_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_RESULT;
          end else if (op_q[1]) begin
            if (a_q >= b_q) begin
              result_q <= a_q - b_q;
            end else begin
              result_q <= b_q - a_q;
              neg_q    <= 1'b1;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_RESULT;
          end else if (op_q[2]) begin
            acc_q  <= mul_acc_d;
            wa_q   <= {wa_q[WIDTH-2:0], 1'b0};
            wb_q   <= {1'b0, wb_q[WIDTH-1:1]};
            step_q <= step_q + STEP_W'(1);
            if (last_step) begin
              result_q <= mul_acc_d;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_RESULT;
            end
          end else if (b_q == '0) begin
            result_q <= '0;
            dz_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_RESULT;
          end else begin
            acc_q  <= div_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            wa_q   <= {wa_q[WIDTH-2:0], div_ge};
            step_q <= step_q + STEP_W'(1);
            if (last_step) begin
              result_q <= {wa_q[WIDTH-2:0], div_ge};
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (set_e) begin
`ifdef CALC_CHAIN_EN
            if (op_onehot && !neg_q && !dz_q) begin
              a_q     <= result_q;
              op_q    <= bus.op;
              entry_q <= '0;
              cnt_q   <= '0;
              state_q <= S_OPB;
            end else begin
              result_q <= '0;
              neg_q    <= 1'b0;
              dz_q     <= 1'b0;
              state_q  <= S_IDLE;
            end
`else
            result_q <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            state_q  <= S_IDLE;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.state       = 3'(state_q);
  assign bus.digit_cnt   = cnt_q;
  assign bus.entry_value = entry_q;
  assign bus.result      = result_q;
  assign bus.result_neg  = neg_q;
  assign bus.div_zero    = dz_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_calc_core_param.sv
// Directed bench for calc_core_param: vector table of full calculations plus
// hand sequences for entry limits, simultaneous buttons, reset in CALC and chaining.
module tb_calc_core_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  calc_core_param_if #(.DIGITS(4), .WIDTH(32)) bus ();

  calc_core_param #(.DIGITS(4), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    logic [3:0]  op;
    logic [31:0] res;
    bit          neg;
    bit          dz;
    int          busy;
    bit          poke;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_set();
    bus.set = 1'b1;
    tick(1);
    bus.set = 1'b0;
    tick(1);
  endtask

  task automatic append_key(input logic [9:0] k);
    bus.key    = k;
    bus.append = 1'b1;
    tick(1);
    bus.append = 1'b0;
    tick(1);
  endtask

  task automatic enter_num(input int unsigned v, output int nd);
    int unsigned dg[$];
    nd = 0;
    while (v != 0) begin
      dg.push_front(v % 10);
      v = v / 10;
      nd++;
    end
    foreach (dg[i]) append_key(10'b1 << dg[i]);
  endtask

  // Fires set from OPB and follows CALC until done, counting busy cycles.
  task automatic run_calc(input bit poke, output int busy_cnt, output bit got_done);
    busy_cnt = 0;
    got_done = 1'b0;
    bus.set  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.set = 1'b0;
      if (poke && c == 5) bus.set = 1'b1;
      if (poke && c == 7) bus.set = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    bus.set = 1'b0;
  endtask

  // From IDLE: enter A, choose op, enter B, start the calculation.
  task automatic setup_ab(input int unsigned a, input int unsigned b, input logic [3:0] op,
                          input string tag);
    int nd;
    press_set();
    enter_num(a, nd);
    check({tag, " entryA"}, bus.entry_value, a);
    check({tag, " cntA"}, 32'(bus.digit_cnt), 32'(nd));
    press_set();
    check({tag, " opsel state"}, 32'(bus.state), 32'd2);
    bus.op = op;
    press_set();
    enter_num(b, nd);
  endtask

  initial begin
    int  bc;
    bit  gd;
    int  nd;
    vecs[0] = '{23,   23,   4'b0001, 32'd46,       1'b0, 1'b0, 1,  1'b0};
    vecs[1] = '{23,   45,   4'b0010, 32'd22,       1'b1, 1'b0, 1,  1'b0};
    vecs[2] = '{9999, 9999, 4'b0100, 32'd99980001, 1'b0, 1'b0, 32, 1'b1};
    vecs[3] = '{7,    2,    4'b1000, 32'd3,        1'b0, 1'b0, 32, 1'b0};
    vecs[4] = '{7,    0,    4'b1000, 32'd0,        1'b0, 1'b1, 1,  1'b0};
    vecs[5] = '{45,   23,   4'b0010, 32'd22,       1'b0, 1'b0, 1,  1'b0};
    vecs[6] = '{0,    0,    4'b0001, 32'd0,        1'b0, 1'b0, 1,  1'b0};
    vecs[7] = '{1234, 7,    4'b1000, 32'd176,      1'b0, 1'b0, 32, 1'b0};
    vecs[8] = '{0,    5,    4'b0100, 32'd0,        1'b0, 1'b0, 32, 1'b0};

    bus.key = '0; bus.append = 1'b0; bus.set = 1'b0; bus.op = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset state", 32'(bus.state), 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset entry", bus.entry_value, 32'd0);
    check("reset flags", {28'd0, bus.result_neg, bus.div_zero, bus.busy, bus.done}, 32'd0);

    // Table of full calculations
    foreach (vecs[i]) begin
      setup_ab(vecs[i].a, vecs[i].b, vecs[i].op, $sformatf("v%0d", i));
      run_calc(vecs[i].poke, bc, gd);
      check($sformatf("v%0d done", i), 32'(gd), 32'd1);
      check($sformatf("v%0d busy cycles", i), 32'(bc), 32'(vecs[i].busy));
      check($sformatf("v%0d result", i), bus.result, vecs[i].res);
      check($sformatf("v%0d neg", i), 32'(bus.result_neg), 32'(vecs[i].neg));
      check($sformatf("v%0d div_zero", i), 32'(bus.div_zero), 32'(vecs[i].dz));
      check($sformatf("v%0d state", i), 32'(bus.state), 32'd5);
      tick(1);
      check($sformatf("v%0d done pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d held result", i), bus.result, vecs[i].res);
      bus.op = 4'b0000;
      press_set();
      check($sformatf("v%0d back idle", i), 32'(bus.state), 32'd0);
      check($sformatf("v%0d idle result", i), bus.result, 32'd0);
    end

    // Entry limits: invalid keys, held append, digit cap
    press_set();
    append_key(10'b0000001100);
    check("multi-key entry", bus.entry_value, 32'd0);
    check("multi-key cnt", 32'(bus.digit_cnt), 32'd0);
    append_key(10'b0);
    check("no-key entry", bus.entry_value, 32'd0);
    bus.key    = 10'b0000000010;
    bus.append = 1'b1;
    tick(100);
    bus.append = 1'b0;
    tick(1);
    check("held append entry", bus.entry_value, 32'd1);
    check("held append cnt", 32'(bus.digit_cnt), 32'd1);
    append_key(10'b1 << 2);
    append_key(10'b1 << 3);
    append_key(10'b1 << 4);
    append_key(10'b1 << 5);
    check("full entry", bus.entry_value, 32'd1234);
    check("full cnt", 32'(bus.digit_cnt), 32'd4);

    // Simultaneous append+set, invalid operator
    rst = 1'b1; tick(1); rst = 1'b0;
    press_set();
    append_key(10'b1 << 5);
    bus.key = 10'b1 << 8; bus.append = 1'b1; bus.set = 1'b1;
    tick(1);
    bus.append = 1'b0; bus.set = 1'b0;
    tick(1);
    check("simul A state", 32'(bus.state), 32'd2);
    check("simul A entry", bus.entry_value, 32'd58);
    bus.op = 4'b0011;
    press_set();
    check("bad op stays", 32'(bus.state), 32'd2);
    bus.op = 4'b0001;
    press_set();
    check("opb state", 32'(bus.state), 32'd3);
    check("opb entry clear", bus.entry_value, 32'd0);
    bus.key = 10'b1 << 2; bus.append = 1'b1;
    run_calc(1'b0, bc, gd);
    bus.append = 1'b0;
    check("simul B done", 32'(gd), 32'd1);
    check("simul B result", bus.result, 32'd60);

    // Reset in the middle of a multiply
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    setup_ab(9999, 9999, 4'b0100, "rstmul");
    bus.set = 1'b1;
    tick(1);
    bus.set = 1'b0;
    tick(9);
    check("mul mid busy", 32'(bus.busy), 32'd1);
    check("mul mid state", 32'(bus.state), 32'd4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort state", 32'(bus.state), 32'd0);
    check("abort outputs", {28'd0, bus.result_neg, bus.div_zero, bus.busy, bus.done}, 32'd0);
    check("abort result", bus.result | bus.entry_value, 32'd0);
    tick(3);
    check("abort stays idle", 32'(bus.state), 32'd0);

    // Chained calculation from RESULT
    setup_ab(23, 23, 4'b0001, "chain");
    run_calc(1'b0, bc, gd);
    check("chain first", bus.result, 32'd46);
    tick(1);
    bus.op = 4'b0100;
    press_set();
`ifdef CALC_CHAIN_EN
    check("chain state", 32'(bus.state), 32'd3);
    enter_num(2, nd);
    run_calc(1'b0, bc, gd);
    check("chain done", 32'(gd), 32'd1);
    check("chain result", bus.result, 32'd92);
    check("chain busy", 32'(bc), 32'd32);
`else
    check("nochain state", 32'(bus.state), 32'd0);
    check("nochain result", bus.result, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
- Parametrised arithmetic core for the push-button calculator, separated from the LCD driver.
- Accepts one-hot decimal digit keys and append/set buttons, assembles two unsigned operands of up to DIGITS digits, and takes a one-hot operator.
- Computes add, sub, mul or div (mul/div are multi-cycle sequential) and presents the result plus status to the display/LED layer.

Parameters:
- DIGITS, 4, maximum decimal digits per operand.
- WIDTH, 32, operand/result width in bits. Must satisfy 10^(2*DIGITS) <= 2^WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- key  in  10  one-hot digit select; bit n = digit n.
- append  in  1  level button; rising edge appends the digit on key.
- set  in  1  level button; rising edge advances the FSM.
- op  in  4  one-hot operator: [0]=add, [1]=sub, [2]=mul, [3]=div.
- state  out  3  FSM state code.
- digit_cnt  out  $clog2(DIGITS+1)  digits entered in the current operand.
- entry_value  out  WIDTH  operand currently being entered (A in OPA, B in OPB).
- result  out  WIDTH  result magnitude.
- result_neg  out  1  result negative (sub only).
- div_zero  out  1  last div had B=0.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse on CALC->RESULT.

Behaviour:
- Reset: all outputs 0; state=IDLE; A, B, op register and edge-detect flops cleared. Reset mid-CALC aborts; next cycle is IDLE.
- Edge detect: app_e/set_e = input & ~prev, prev registered. An event acts on the cycle after the input rises. A held level produces one event only.
- State codes: IDLE=0, OPA=1, OPSEL=2, OPB=3, CALC=4, RESULT=5.
- IDLE: set_e -> OPA. digit_cnt and entry_value clear; result, result_neg and div_zero clear.
- OPA/OPB, on app_e:
  - If key has exactly one bit set and digit_cnt<DIGITS: entry=entry*10+index, digit_cnt++.
  - Else (zero/multiple bits, or digits full): ignored, no change.
- OPA: set_e latches A=entry -> OPSEL. Zero digits is legal and gives A=0.
- OPSEL:
  - set_e with op exactly one-hot: latch op, clear entry/digit_cnt -> OPB.
  - set_e otherwise: ignored, stay in OPSEL.
- OPB: set_e latches B=entry -> CALC.
- CALC: busy=1; app_e/set_e discarded.
  - add: result=A+B, 1 cycle.
  - sub: if A>=B, result=A-B, neg=0; else result=B-A, neg=1. 1 cycle.
  - mul: shift-add, exactly WIDTH cycles.
  - div: restoring division, exactly WIDTH cycles; quotient to result, remainder dropped.
  - div with B=0: 1 cycle, result=0, div_zero=1.
- CALC->RESULT: done=1 for one cycle.
- RESULT: outputs held; set_e -> IDLE. app_e ignored.
- Simultaneous app_e and set_e in OPA/OPB: the append is applied first, then set latches the updated entry in the same cycle.
- entry_value mirrors the entry register in every state; it is 0 in IDLE, CALC and RESULT.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined, in RESULT on set_e:
  - op exactly one-hot, result_neg=0 and div_zero=0: A=result, latch op -> OPB (chained calculation).
  - Otherwise -> IDLE.
- Undefined: RESULT set_e always -> IDLE and op is not sampled there.

Test Plan:
- Basic add: rst; set; enter keys 0b100 then 0b1000 (A=23); set; op=0001, set; enter B=23; set -> done after 1 cycle, result=46, neg=0, state=5.
- Sub negative: A=23, B=45, op=0010 -> result=22, result_neg=1.
- Mul latency: A=9999, B=9999, op=0100 -> busy for exactly 32 cycles, result=99980001. A second set inside CALC is ignored.
- Div and div-by-zero:
  - 7/2 -> result=3 after 32 cycles.
  - 7/0 -> div_zero=1, result=0, 1 cycle.
- Entry limits:
  - Five appends 1,2,3,4,5 -> entry_value=1234, digit_cnt=4.
  - key=0b1100 append -> no change.
  - append held 100 cycles -> one digit only.
- Mid-op and chain:
  - rst asserted during mul -> state=0, all outputs 0 next cycle.
  - With CALC_CHAIN_EN: 23+23=46, then op=0100 + set, B=2 -> result=92.
